// File: rtl/int_divider_pkg.sv
// int_divider_pkg: shared definitions for the int_divider block.
//   - DEFAULT_WIDTH : default operand/result width; follows the codebase-wide
//                     DATAWIDTH define, which defaults to 32 when not set.
//   - ST_*          : 3-bit state encodings (IDLE/PREP/CALC/FIX/DONE).
//   - div_state_e   : enum built on those encodings, used by the FSM.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

package int_divider_pkg;

  localparam int DEFAULT_WIDTH = `DATAWIDTH;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PREP = 3'd1;
  localparam logic [2:0] ST_CALC = 3'd2;
  localparam logic [2:0] ST_FIX  = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_PREP = ST_PREP,
    S_CALC = ST_CALC,
    S_FIX  = ST_FIX,
    S_DONE = ST_DONE
  } div_state_e;

endpackage

// File: rtl/int_divider_div_step.sv
// int_divider_div_step: one combinational radix-2 restoring iteration.
// Ports:
//   rem_i  [WIDTH-1:0] partial remainder before the step
//   quo_i  [WIDTH-1:0] dividend/quotient shift register before the step
//   dvs_i  [WIDTH-1:0] divisor magnitude
//   rem_o  [WIDTH-1:0] partial remainder after the step
//   quo_o  [WIDTH-1:0] quotient register after the step (new bit in LSB)
module int_divider_div_step
    import int_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // The shifted remainder can reach 2*|divisor|-1, so the trial
    // subtraction needs one extra bit; its MSB is the borrow.
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        diff    = shifted - {1'b0, dvs_i};
        if (!diff[WIDTH]) begin
            rem_o = diff[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b1};
        end else begin
            rem_o = shifted[WIDTH-1:0];
            quo_o = {quo_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/int_divider.sv
// int_divider: iterative radix-2 restoring divider, signed or unsigned.
// Optional feature macro: INT_DIVIDER_EARLY_OUT_EN (skip iteration when
// |dividend| < |divisor|; results identical, latency 2 instead of WIDTH+2).
// Handshakes: a transfer happens on a rising edge where valid && ready.
//   Input side accepts only in IDLE; output side holds its data stable
//   while out_valid && !out_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake
//   is_signed             1 = two's-complement, 0 = unsigned
//   dividend, divisor     operands, captured on accept
//   out_valid / out_ready result handshake
//   quotient, remainder   registered results
//   div_by_zero           result came from divisor == 0
//   busy                  request in flight
//   dbg_state             current FSM state encoding
module int_divider
    import int_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             busy,
    output logic [2:0]       dbg_state
);

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // raw dividend as captured
    logic [WIDTH-1:0] dvs_q, dvs_d;       // raw divisor, then |divisor| from PREP on
    logic             sgn_q, sgn_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             raw_q, raw_d;       // special result: load without sign fix
    logic             zero_q, zero_d;     // divide-by-zero flag for FIX
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] abs_dvd, abs_dvs;
    logic [WIDTH-1:0] step_rem, step_quo;

    assign abs_dvd = (sgn_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
    assign abs_dvs = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;

    int_divider_div_step #(.WIDTH(WIDTH)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .dvs_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dvd_d       = dvd_q;
        dvs_d       = dvs_q;
        sgn_d       = sgn_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        raw_d       = raw_q;
        zero_d      = zero_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    sgn_d   = is_signed;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                q_neg_d = sgn_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                r_neg_d = sgn_q && dvd_q[WIDTH-1];
                zero_d  = (dvs_q == '0);
                raw_d   = 1'b0;
                if (dvs_q == '0) begin
                    quo_d   = ALL_ONES;
                    rem_d   = dvd_q;
                    raw_d   = 1'b1;
                    state_d = S_FIX;
                end else if (sgn_q && dvd_q == MIN_VAL && dvs_q == ALL_ONES) begin
                    quo_d   = MIN_VAL;
                    rem_d   = '0;
                    raw_d   = 1'b1;
                    state_d = S_FIX;
`ifdef INT_DIVIDER_EARLY_OUT_EN
                end else if (abs_dvd < abs_dvs) begin
                    quo_d   = '0;
                    rem_d   = abs_dvd;
                    state_d = S_FIX;
`endif
                end else begin
                    quo_d   = abs_dvd;
                    rem_d   = '0;
                    dvs_d   = abs_dvs;
                    cnt_d   = CNT_W'(WIDTH);
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (raw_q) begin
                    quotient_d  = quo_q;
                    remainder_d = rem_q;
                end else begin
                    // Negating a zero quotient leaves zero, so no sign on 0.
                    quotient_d  = q_neg_q ? -quo_q : quo_q;
                    remainder_d = r_neg_q ? -rem_q : rem_q;
                end
                dbz_d   = zero_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            dvd_q       <= '0;
            dvs_q       <= '0;
            sgn_q       <= 1'b0;
            rem_q       <= '0;
            quo_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            raw_q       <= 1'b0;
            zero_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dvd_q       <= dvd_d;
            dvs_q       <= dvs_d;
            sgn_q       <= sgn_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            raw_q       <= raw_d;
            zero_q      <= zero_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q != S_IDLE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_int_divider.sv
module tb_int_divider;

  localparam int W = 32;
  localparam logic [W-1:0] MINV = 32'h8000_0000;
`ifdef INT_DIVIDER_EARLY_OUT_EN
  localparam int L_SMALL = 2;
`else
  localparam int L_SMALL = W + 2;
`endif
  localparam int L_FULL = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         busy;
  logic [2:0]   dbg_state;

  int tests = 0;
  int fails = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .is_signed   (is_signed),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Truncating division on 64-bit integers; special cases from the rules.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z, output int lat);
    longint sa, sb, ma, mb;
    sa = s ? longint'($signed(a)) : longint'(a);
    sb = s ? longint'($signed(b)) : longint'(b);
    ma = (sa < 0) ? -sa : sa;
    mb = (sb < 0) ? -sb : sb;
    z = 1'b0;
    lat = L_FULL;
    if (b == '0) begin
      q = '1; r = a; z = 1'b1; lat = 2;
    end else if (s && a == MINV && b == '1) begin
      q = MINV; r = '0; lat = 2;
    end else begin
      q = W'(sa / sb);
      r = W'(sa % sb);
`ifdef INT_DIVIDER_EARLY_OUT_EN
      if (ma < mb) lat = 2;
`else
      if (ma < mb) lat = L_FULL;
`endif
    end
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input logic ez,
                       input int elat, input int hold);
    int lat;
    int guard;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    check("in_ready_before_req", 64'(in_ready), 64'd1);
    dividend = a; divisor = b; is_signed = s; in_valid = 1'b1;
    @(posedge clk); #1;
    // Scramble inputs after the accept edge; they must be ignored.
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom; is_signed = 1'($urandom_range(0, 1));
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
    check("latency", 64'(lat), 64'(elat));
    if (!out_valid) begin
      rst_n = 1'b0; #3; rst_n = 1'b1;
      @(negedge clk);
      return;
    end
    check("quotient", 64'(quotient), 64'(eq));
    check("remainder", 64'(remainder), 64'(er));
    check("div_by_zero", 64'(div_by_zero), 64'(ez));
    check("busy_done", 64'(busy), 64'd1);
    check("in_ready_done", 64'(in_ready), 64'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_quotient", 64'(quotient), 64'(eq));
      check("hold_remainder", 64'(remainder), 64'(er));
      check("hold_dbz", 64'(div_by_zero), 64'(ez));
      check("hold_in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_valid", 64'(out_valid), 64'd0);
    check("post_in_ready", 64'(in_ready), 64'd1);
    check("post_busy", 64'(busy), 64'd0);
    check("idle_quotient_kept", 64'(quotient), 64'(eq));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] a, b, q, r;
    logic s, z;
    int lat;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_dbz", 64'(div_by_zero), 64'd0);
    check("rst_quotient", 64'(quotient), 64'd0);
    check("rst_remainder", 64'(remainder), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases with hand-derived results.
    do_op(32'd12, 32'd9, 1'b0, 32'd1, 32'd3, 1'b0, L_FULL, 0);
    do_op(32'hFFFF_FFFF, 32'd3, 1'b0, 32'h5555_5555, 32'd0, 1'b0, L_FULL, 1);
    do_op(32'hFFFF_FFFF, 32'd3, 1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, L_SMALL, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, L_FULL, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, L_FULL, 0);
    do_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);
    do_op(32'd5, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'd5, 1'b1, 2, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 2, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, L_SMALL, 0);
    do_op(32'd3, 32'd9, 1'b0, 32'd0, 32'd3, 1'b0, L_SMALL, 0);
    do_op(32'd0, 32'd5, 1'b1, 32'd0, 32'd0, 1'b0, L_SMALL, 0);
    // Backpressure for 10 cycles, then a back-to-back request.
    do_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, L_FULL, 10);
    do_op(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0, L_FULL, 0);

    // Asynchronous reset in the middle of CALC.
    dividend = 32'd1234567; divisor = 32'd89; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_quotient", 64'(quotient), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("after_rst_out_valid", 64'(out_valid), 64'd0);
    do_op(32'd1234567, 32'd89, 1'b0, 32'd13871, 32'd48, 1'b0, L_FULL, 0);

    // Randomized cases checked against the reference model.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? W'($urandom_range(1, 15)) : W'($urandom);
      if (kind == 0) b = '0;
      if (kind == 1) begin a = MINV; b = '1; s = 1'b1; end
      if (kind == 2) begin a = W'($urandom_range(0, 50)); b = W'($urandom_range(51, 1000)); end
      if (kind == 3) begin a = -W'($urandom_range(1, 50)); b = W'($urandom_range(2, 9)); s = 1'b1; end
      ref_div(a, b, s, q, r, z, lat);
      do_op(a, b, s, q, r, z, lat, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
